// File: rtl/ysyx_23060061_arbiter.sv
// Arbiter: grants the single crossbar master port to IFU reads, LSU reads or LSU writes, one transaction at a time.
// Latency: a grant takes effect 1 cycle after the request is sampled in IDLE; once granted, channels pass through combinationally.
// Backpressure: ready/valid pass straight through to the owning master; non-owners see all-zero outputs until the bus frees.
// Optional feature: define YSYX_23060061_ARBITER_RR_EN to alternate IFU/LSU on simultaneous requests (last-grant register).
module ysyx_23060061_arbiter (
    input  logic        clk,
    input  logic        rst,
    // IFU read-address / read-data channels
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    // LSU read channels
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    // LSU write channels
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    // master port to the crossbar
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IFU   = 2'd1,
        S_LSU_R = 2'd2,
        S_LSU_W = 2'd3
    } state_e;

    state_e state_q, state_d;

    // A write needs both address and data offered before it is granted.
    logic lsu_wr_req, lsu_rd_req, ifu_rd_req;
    assign lsu_wr_req = lsu_awvalid && lsu_wvalid;
    assign lsu_rd_req = lsu_arvalid;
    assign ifu_rd_req = ifu_arvalid;

`ifdef YSYX_23060061_ARBITER_RR_EN
    // 1 when the IFU was the most recent master granted, 0 when the LSU was.
    logic last_ifu_q, last_ifu_d;

    // State and last-grant registers; reset forgets any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            last_ifu_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_ifu_q <= last_ifu_d;
        end
    end
`else
    // State register; reset forgets any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end
`endif

    // Next state: arbitrate only from IDLE, release the bus on the final response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef YSYX_23060061_ARBITER_RR_EN
                // On a tie the IFU wins only if the LSU was served last; otherwise fall through to LSU-first.
                if (ifu_rd_req && (lsu_wr_req || lsu_rd_req) && !last_ifu_q) state_d = S_IFU;
                else if (lsu_wr_req) state_d = S_LSU_W;
`else
                if (lsu_wr_req)      state_d = S_LSU_W;
`endif
                else if (lsu_rd_req) state_d = S_LSU_R;
                else if (ifu_rd_req) state_d = S_IFU;
            end
            S_IFU:   if (rvalid && ifu_rready) state_d = S_IDLE;
            S_LSU_R: if (rvalid && lsu_rready) state_d = S_IDLE;
            S_LSU_W: if (bvalid && lsu_bready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef YSYX_23060061_ARBITER_RR_EN
    // Record which side received the grant whenever the bus leaves IDLE.
    always_comb begin
        last_ifu_d = last_ifu_q;
        if (state_q == S_IDLE && state_d != S_IDLE) last_ifu_d = (state_d == S_IFU);
    end
`endif

    // Output routing: connect only the owner's channels, everything else driven to 0.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = 32'h0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = 32'h0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;
        araddr      = 32'h0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awaddr      = 32'h0;
        awvalid     = 1'b0;
        wdata       = 32'h0;
        wstrb       = 4'h0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        case (state_q)
            S_IFU: begin
                araddr      = ifu_araddr;
                arvalid     = ifu_arvalid;
                ifu_arready = arready;
                ifu_rdata   = rdata;
                ifu_rresp   = rresp;
                ifu_rvalid  = rvalid;
                rready      = ifu_rready;
            end
            S_LSU_R: begin
                araddr      = lsu_araddr;
                arvalid     = lsu_arvalid;
                lsu_arready = arready;
                lsu_rdata   = rdata;
                lsu_rresp   = rresp;
                lsu_rvalid  = rvalid;
                rready      = lsu_rready;
            end
            S_LSU_W: begin
                awaddr      = lsu_awaddr;
                awvalid     = lsu_awvalid;
                lsu_awready = awready;
                wdata       = lsu_wdata;
                wstrb       = lsu_wstrb;
                wvalid      = lsu_wvalid;
                lsu_wready  = wready;
                lsu_bresp   = bresp;
                lsu_bvalid  = bvalid;
                bready      = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060061_arbiter.sv
// Bench for ysyx_23060061_arbiter: directed scenarios followed by random traffic against a bus-ownership model.
// Latency: model expects the grant one cycle after the request edge, and combinational pass-through afterwards.
// Backpressure: slave and master ready/valid signals are driven freely; the model decides who owns the bus.
module tb_ysyx_23060061_arbiter;

`ifdef YSYX_23060061_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam int OWN_NONE = 0;
    localparam int OWN_IFU  = 1;
    localparam int OWN_RD   = 2;
    localparam int OWN_WR   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;  logic ifu_arvalid; logic ifu_arready;
    logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp; logic ifu_rvalid; logic ifu_rready;
    logic [31:0] lsu_araddr;  logic lsu_arvalid; logic lsu_arready;
    logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp; logic lsu_rvalid; logic lsu_rready;
    logic [31:0] lsu_awaddr;  logic lsu_awvalid; logic lsu_awready;
    logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb; logic lsu_wvalid; logic lsu_wready;
    logic [1:0]  lsu_bresp;   logic lsu_bvalid;  logic lsu_bready;
    logic [31:0] araddr;      logic arvalid;     logic arready;
    logic [31:0] rdata;       logic [1:0] rresp; logic rvalid; logic rready;
    logic [31:0] awaddr;      logic awvalid;     logic awready;
    logic [31:0] wdata;       logic [3:0] wstrb; logic wvalid; logic wready;
    logic [1:0]  bresp;       logic bvalid;      logic bready;

    ysyx_23060061_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: who owns the bus, and which master was granted last.
    int own     = OWN_NONE;
    bit last_ifu = 1'b0;
    int own_n;
    bit last_ifu_n;

    // Spec arbitration rule: LSU-first, with IFU winning a tie when alternation is on and LSU went last.
    function automatic int pick(bit w, bit r, bit i, bit lastifu);
        if (RR && i && (w || r) && !lastifu) return OWN_IFU;
        if (w) return OWN_WR;
        if (r) return OWN_RD;
        if (i) return OWN_IFU;
        return OWN_NONE;
    endfunction

    function automatic void model_next();
        own_n      = own;
        last_ifu_n = last_ifu;
        if (!rst) begin
            own_n      = OWN_NONE;
            last_ifu_n = 1'b0;
        end else if (own == OWN_NONE) begin
            own_n = pick(lsu_awvalid && lsu_wvalid, lsu_arvalid, ifu_arvalid, last_ifu);
            if (own_n != OWN_NONE) last_ifu_n = (own_n == OWN_IFU);
        end else if (own == OWN_IFU && rvalid && ifu_rready) own_n = OWN_NONE;
        else if (own == OWN_RD && rvalid && lsu_rready)      own_n = OWN_NONE;
        else if (own == OWN_WR && bvalid && lsu_bready)      own_n = OWN_NONE;
    endfunction

    function automatic logic [181:0] obs_bus();
        return {ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
                lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
                lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
                araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready};
    endfunction

    // Expected port values given the modelled owner: the owner is wired through, everything else is 0.
    function automatic logic [181:0] exp_bus();
        case (own)
            OWN_IFU: return {arready, rdata, rresp, rvalid,
                             1'b0, 32'h0, 2'b0, 1'b0,
                             1'b0, 1'b0, 2'b0, 1'b0,
                             ifu_araddr, ifu_arvalid, ifu_rready, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0};
            OWN_RD:  return {1'b0, 32'h0, 2'b0, 1'b0,
                             arready, rdata, rresp, rvalid,
                             1'b0, 1'b0, 2'b0, 1'b0,
                             lsu_araddr, lsu_arvalid, lsu_rready, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0};
            OWN_WR:  return {1'b0, 32'h0, 2'b0, 1'b0,
                             1'b0, 32'h0, 2'b0, 1'b0,
                             awready, wready, bresp, bvalid,
                             32'h0, 1'b0, 1'b0, lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid, lsu_bready};
            default: return '0;
        endcase
    endfunction

    task automatic chk_bus(input string tag);
        logic [181:0] o, e;
        o = obs_bus();
        e = exp_bus();
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    // Advance one clock edge; the model sees the same inputs the DUT samples.
    task automatic tick();
        model_next();
        @(posedge clk);
        own      = own_n;
        last_ifu = last_ifu_n;
        #1;
    endtask

    task automatic clear_inputs();
        ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
        lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0; lsu_bready = 0;
        arready = 0; rdata = '0; rresp = '0; rvalid = 0;
        awready = 0; wready = 0; bresp = '0; bvalid = 0;
    endtask

    task automatic rand_inputs();
        ifu_araddr  = $urandom; ifu_arvalid = 1'($urandom_range(0, 1)); ifu_rready = ($urandom_range(0, 3) != 0);
        lsu_araddr  = $urandom; lsu_arvalid = 1'($urandom_range(0, 1)); lsu_rready = ($urandom_range(0, 3) != 0);
        lsu_awaddr  = $urandom; lsu_awvalid = 1'($urandom_range(0, 1));
        lsu_wdata   = $urandom; lsu_wstrb = 4'($urandom); lsu_wvalid = 1'($urandom_range(0, 1));
        lsu_bready  = ($urandom_range(0, 3) != 0);
        arready = 1'($urandom_range(0, 1)); rdata = $urandom; rresp = 2'($urandom); rvalid = ($urandom_range(0, 2) == 0);
        awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1));
        bresp = 2'($urandom); bvalid = ($urandom_range(0, 2) == 0);
        rst = ($urandom_range(0, 63) != 0);
    endtask

    initial begin
        // Reset
        clear_inputs();
        rst = 1'b0;
        tick(); tick();
        #1; chk_bus("reset_bus");
        chk32("reset_arvalid", 32'(arvalid), 32'h0);
        rst = 1'b1;

        // IFU read with a one-cycle slave response
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1; arready = 1;
        #1; chk32("ifu_idle_arvalid", 32'(arvalid), 32'h0);
        chk_bus("ifu_idle_bus");
        tick();
        chk32("ifu_araddr", araddr, 32'h8000_0000);
        chk32("ifu_arready", 32'(ifu_arready), 32'h1);
        tick();
        ifu_arvalid = 0; rvalid = 1; rdata = 32'h0000_0413; ifu_rready = 1;
        #1; chk32("ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk32("ifu_rvalid", 32'(ifu_rvalid), 32'h1);
        tick();
        clear_inputs();
        #1; chk_bus("ifu_back_idle");

        // Same-cycle IFU and LSU reads: LSU first (IFU was last granted, so also true with alternation)
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1; arready = 1;
        #1; tick();
        chk32("tie_lsu_araddr", araddr, 32'h8000_1000);
        chk32("tie_ifu_arready", 32'(ifu_arready), 32'h0);
        tick();
        lsu_arvalid = 0; rvalid = 1; rdata = 32'h1234_5678; lsu_rready = 1;
        #1; chk32("tie_lsu_rvalid", 32'(lsu_rvalid), 32'h1);
        chk32("tie_ifu_arready_r", 32'(ifu_arready), 32'h0);
        tick();
        rvalid = 0; lsu_rready = 0;
        #1; chk32("tie_gap_ifu_arready", 32'(ifu_arready), 32'h0);
        chk_bus("tie_gap_bus");
        tick();
        chk32("tie_ifu_later", araddr, 32'h8000_0000);
        tick();
        ifu_arvalid = 0; rvalid = 1; ifu_rready = 1;
        #1; tick();
        clear_inputs();

        // LSU write while an LSU read is also offered: write wins, AR side stays quiet
        lsu_awaddr = 32'ha000_03f8; lsu_awvalid = 1; lsu_wdata = 32'h41; lsu_wstrb = 4'h1; lsu_wvalid = 1;
        lsu_araddr = 32'h0000_1234; lsu_arvalid = 1; awready = 1; wready = 1;
        #1; tick();
        chk32("wr_awaddr", awaddr, 32'ha000_03f8);
        chk32("wr_wdata", wdata, 32'h41);
        chk32("wr_wstrb", 32'(wstrb), 32'h1);
        chk32("wr_arvalid", 32'(arvalid), 32'h0);
        tick();
        lsu_awvalid = 0; lsu_wvalid = 0; lsu_arvalid = 0;
        bvalid = 1; bresp = 2'b00; lsu_bready = 0;
        #1; chk_bus("wr_hold_no_bready");
        tick();
        lsu_bready = 1;
        #1; chk32("wr_bvalid", 32'(lsu_bvalid), 32'h1);
        tick();
        clear_inputs();
        #1; chk_bus("wr_back_idle");

        // LSU read with error response
        lsu_araddr = 32'h8000_2000; lsu_arvalid = 1; arready = 1;
        #1; tick();
        lsu_arvalid = 0; rvalid = 1; rresp = 2'b10; lsu_rready = 1;
        #1; chk32("err_rresp", 32'(lsu_rresp), 32'h2);
        chk32("err_ifu_rvalid", 32'(ifu_rvalid), 32'h0);
        tick();
        clear_inputs();
        ifu_arvalid = 1;
        #1; chk32("err_next_idle", 32'(ifu_arready), 32'h0);
        clear_inputs();

        // Reset in the middle of an LSU read
        lsu_araddr = 32'h8000_3000; lsu_arvalid = 1; arready = 1;
        #1; tick();
        chk32("rst_lsu_arvalid", 32'(arvalid), 32'h1);
        rst = 0;
        #1; tick();
        chk_bus("rst_mid_bus");
        chk32("rst_mid_arvalid", 32'(arvalid), 32'h0);
        rst = 1; lsu_arvalid = 0;
        ifu_araddr = 32'h8000_0040; ifu_arvalid = 1;
        #1; tick();
        chk32("rst_ifu_araddr", araddr, 32'h8000_0040);
        tick();
        ifu_arvalid = 0; rvalid = 1; ifu_rready = 1;
        #1; tick();
        clear_inputs();

        // Two consecutive ties from a fresh reset: alternation gives IFU then LSU, fixed priority gives LSU twice
        rst = 0; #1; tick(); rst = 1;
        for (int t = 0; t < 2; t++) begin
            ifu_araddr = 32'h8000_0100; ifu_arvalid = 1;
            lsu_araddr = 32'h8000_0200; lsu_arvalid = 1; arready = 1;
            #1; tick();
            chk32($sformatf("tie%0d_winner", t), araddr,
                  (RR && t == 0) ? 32'h8000_0100 : 32'h8000_0200);
            tick();
            ifu_arvalid = 0; lsu_arvalid = 0; rvalid = 1; ifu_rready = 1; lsu_rready = 1;
            #1; tick();
            clear_inputs();
            #1;
        end

        // Random traffic, every cycle checked against the ownership model
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            #1; chk_bus("rand_bus");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
